// File: rtl/target_generator.sv
// -----------------------------------------------------------------------------
// target_generator
//
// Food-target source for the snake game. It holds the current target cell on
// the 160x120 grid. When the snake head reaches the target, it bumps the score
// and searches two free-running LFSRs for a new in-range cell. WIN asserts
// once the score reaches WIN_SCORE.
//
// Parameters:
//   MAX_X      largest legal target column
//   MAX_Y      largest legal target row
//   INIT_X     target column after reset / game start
//   INIT_Y     target row after reset / game start
//   WIN_SCORE  score at which WIN asserts (1..255)
//
// Compile-time option:
//   TARGET_AVOID_EDGE_EN  when defined, targets are drawn only from
//                         1..MAX_X-1 / 1..MAX_Y-1, so they never lie on the
//                         border. INIT_X/INIT_Y must then lie in that range.
//
// Ports:
//   CLK           in   system clock
//   RESET         in   asynchronous, active-high reset; release is expected
//                      to be synchronous to CLK
//   M_STATE[1:0]  in   master state: 00 start, 01 play, 10 win, 11 unused
//   REACHED       in   one-cycle pulse: snake head is on the target
//   TARGET_H[7:0] out  target column
//   TARGET_V[6:0] out  target row
//   TARGET_VALID  out  high when TARGET_H/V is a settled target
//   SCORE[7:0]    out  targets eaten this game
//   WIN           out  high while SCORE == WIN_SCORE (one cycle of lag)
// -----------------------------------------------------------------------------
module target_generator #(
    parameter int MAX_X     = 159,
    parameter int MAX_Y     = 119,
    parameter int INIT_X    = 40,
    parameter int INIT_Y    = 30,
    parameter int WIN_SCORE = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] M_STATE,
    input  logic       REACHED,
    output logic [7:0] TARGET_H,
    output logic [6:0] TARGET_V,
    output logic       TARGET_VALID,
    output logic [7:0] SCORE,
    output logic       WIN
);

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_SEARCH = 1'b1
    } state_e;

    localparam logic [1:0] M_START = 2'b00;
    localparam logic [1:0] M_PLAY  = 2'b01;

    localparam logic [7:0] INIT_H  = 8'(INIT_X);
    localparam logic [6:0] INIT_V  = 7'(INIT_Y);
    localparam logic [7:0] WIN_SC  = 8'(WIN_SCORE);

    localparam logic [7:0] LFSR_H_SEED = 8'hB4;
    localparam logic [6:0] LFSR_V_SEED = 7'h55;

    // Feedback taps: x^8+x^6+x^5+x^4+1 (bits 7,5,4,3) and x^7+x^6+1 (bits 6,5).
    // Both are maximal length, giving coprime periods 255 and 127.
    localparam logic [7:0] LFSR_H_TAPS = 8'b1011_1000;
    localparam logic [6:0] LFSR_V_TAPS = 7'b110_0000;

`ifdef TARGET_AVOID_EDGE_EN
    localparam logic [7:0] H_MAX = 8'(MAX_X - 1);
    localparam logic [6:0] V_MAX = 7'(MAX_Y - 1);
`else
    localparam logic [7:0] H_MAX = 8'(MAX_X);
    localparam logic [6:0] V_MAX = 7'(MAX_Y);
`endif

    state_e     state_q, state_d;
    logic [7:0] target_h_q, target_h_d;
    logic [6:0] target_v_q, target_v_d;
    logic [7:0] score_q, score_d;
    logic       win_q, win_d;
    logic [7:0] lfsr_h_q, lfsr_h_d;
    logic [6:0] lfsr_v_q, lfsr_v_d;
    logic       cand_ok;
    logic       hit;

    // Free-running LFSRs: they step every cycle, independent of game state,
    // so the candidate seen in SEARCH depends on when the target was eaten.
    assign lfsr_h_d = {lfsr_h_q[6:0], ^(lfsr_h_q & LFSR_H_TAPS)};
    assign lfsr_v_d = {lfsr_v_q[5:0], ^(lfsr_v_q & LFSR_V_TAPS)};

    // The current LFSR pair is the candidate; comparisons are unsigned.
`ifdef TARGET_AVOID_EDGE_EN
    assign cand_ok = (lfsr_h_q != 8'd0) && (lfsr_h_q <= H_MAX) &&
                     (lfsr_v_q != 7'd0) && (lfsr_v_q <= V_MAX);
`else
    assign cand_ok = (lfsr_h_q <= H_MAX) && (lfsr_v_q <= V_MAX);
`endif

    // A hit only counts while playing and before the game is won.
    assign hit = REACHED && (M_STATE == M_PLAY) && !win_q;

    // WIN lags SCORE by one edge and falls one edge after SCORE clears.
    assign win_d = (score_q == WIN_SC);

    always_comb begin
        // NOTE: every next-state signal gets its default first; without it
        // the branches below that leave a signal unassigned would infer latches.
        state_d    = state_q;
        target_h_d = target_h_q;
        target_v_d = target_v_q;
        score_d    = score_q;

        if (M_STATE == M_START) begin
            // Game (re)start overrides everything, including an open search.
            state_d    = ST_ACTIVE;
            target_h_d = INIT_H;
            target_v_d = INIT_V;
            score_d    = 8'd0;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (hit) begin
                        state_d = ST_SEARCH;
                        score_d = (score_q >= WIN_SC) ? WIN_SC : score_q + 8'd1;
                    end
                end
                ST_SEARCH: begin
                    // REACHED is ignored here; keep drawing until a pair fits.
                    if (cand_ok) begin
                        state_d    = ST_ACTIVE;
                        target_h_d = lfsr_h_q;
                        target_v_d = lfsr_v_q;
                    end
                end
                default: state_d = ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_ACTIVE;
            target_h_q <= INIT_H;
            target_v_q <= INIT_V;
            score_q    <= 8'd0;
            win_q      <= 1'b0;
            lfsr_h_q   <= LFSR_H_SEED;
            lfsr_v_q   <= LFSR_V_SEED;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, so update order inside this block is irrelevant.
            state_q    <= state_d;
            target_h_q <= target_h_d;
            target_v_q <= target_v_d;
            score_q    <= score_d;
            win_q      <= win_d;
            lfsr_h_q   <= lfsr_h_d;
            lfsr_v_q   <= lfsr_v_d;
        end
    end

    assign TARGET_H     = target_h_q;
    assign TARGET_V     = target_v_q;
    assign TARGET_VALID = (state_q == ST_ACTIVE);
    assign SCORE        = score_q;
    assign WIN          = win_q;

endmodule

// File: tb/tb_target_generator.sv
// -----------------------------------------------------------------------------
// tb_target_generator
//
// Directed bench for target_generator. Inputs are driven and outputs sampled
// on the falling clock edge. A reference LFSR trace from seeds B4/55 predicts
// each new target and the number of search cycles; hand-derived vectors pin
// the first target after reset, (72,95) after a 3-cycle search.
// -----------------------------------------------------------------------------
module tb_target_generator;

    localparam int MAX_X        = 159;
    localparam int MAX_Y        = 119;
    localparam int INIT_X       = 40;
    localparam int INIT_Y       = 30;
    localparam int WIN_SCORE    = 10;
    localparam int SEARCH_BOUND = 64;
    localparam int RAND_PULSES  = 10000;

    logic       clk;
    logic       rst;
    logic [1:0] m_state;
    logic       reached;
    logic [7:0] target_h;
    logic [6:0] target_v;
    logic       target_valid;
    logic [7:0] score;
    logic       win;

    int vectors    = 0;
    int miscompares = 0;

    int         exp_score;
    logic [7:0] exp_h;
    logic [6:0] exp_v;
    int         last_wait;

    logic [7:0] m_h;
    logic [6:0] m_v;

    target_generator dut (
        .CLK          (clk),
        .RESET        (rst),
        .M_STATE      (m_state),
        .REACHED      (reached),
        .TARGET_H     (target_h),
        .TARGET_V     (target_v),
        .TARGET_VALID (target_valid),
        .SCORE        (score),
        .WIN          (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] step_h(input logic [7:0] h);
        return {h[6:0], h[7] ^ h[5] ^ h[4] ^ h[3]};
    endfunction

    function automatic logic [6:0] step_v(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    function automatic bit legal(input logic [7:0] h, input logic [6:0] v);
`ifdef TARGET_AVOID_EDGE_EN
        return (int'(h) >= 1) && (int'(h) <= MAX_X - 1) &&
               (int'(v) >= 1) && (int'(v) <= MAX_Y - 1);
`else
        return (int'(h) <= MAX_X) && (int'(v) <= MAX_Y);
`endif
    endfunction

    // Reference LFSR trace, advancing on the same edges as the design.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_h <= 8'hB4;
            m_v <= 7'h55;
        end else begin
            m_h <= step_h(m_h);
            m_v <= step_v(m_v);
        end
    end

    // From the pair the design will test on the next edge, find the first
    // legal pair and how many edges it takes to reach it.
    task automatic predict(input logic [7:0] h_in, input logic [6:0] v_in,
                           output logic [7:0] h_out, output logic [6:0] v_out,
                           output int n);
        logic [7:0] h;
        logic [6:0] v;
        h = h_in;
        v = v_in;
        n = 1;
        while (!legal(h, v) && n < 1000) begin
            h = step_h(h);
            v = step_v(v);
            n++;
        end
        h_out = h;
        v_out = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_h"},     32'(target_h),     32'(exp_h));
        check({tag, "_v"},     32'(target_v),     32'(exp_v));
        check({tag, "_valid"}, 32'(target_valid), 32'd1);
        check({tag, "_score"}, 32'(score),        32'(exp_score));
    endtask

    // Pulse REACHED (optionally held a second cycle, which lands in SEARCH)
    // and follow the resulting search, if any.
    task automatic pulse(input bit hold2);
        logic [7:0] ph;
        logic [6:0] pv;
        int         n;
        int         waited;
        bit         srch;

        srch   = (exp_score < WIN_SCORE);
        waited = 0;
        reached = 1'b1;
        @(negedge clk);
        if (!hold2) reached = 1'b0;
        if (srch) exp_score++;
        check("hit_score", 32'(score), 32'(exp_score));
        check("hit_valid", 32'(target_valid), srch ? 32'd0 : 32'd1);
        if (srch) begin
            predict(m_h, m_v, ph, pv, n);
            for (int i = 1; i <= SEARCH_BOUND; i++) begin
                @(negedge clk);
                reached = 1'b0;
                if (target_valid) begin
                    waited = i;
                    break;
                end
            end
            check("search_len", 32'(waited), 32'(n));
            exp_h = ph;
            exp_v = pv;
        end else if (hold2) begin
            @(negedge clk);
            reached = 1'b0;
        end
        check("tgt_h", 32'(target_h), 32'(exp_h));
        check("tgt_v", 32'(target_v), 32'(exp_v));
        check("tgt_range", 32'(legal(target_h, target_v)), 32'd1);
        check("score_hold", 32'(score), 32'(exp_score));
        last_wait = waited;
    endtask

    // One cycle of M_STATE=00 (with a stray REACHED) restarts the game.
    task automatic clear_game();
        m_state = 2'b00;
        reached = 1'b1;
        @(negedge clk);
        m_state = 2'b01;
        reached = 1'b0;
        exp_score = 0;
        exp_h = 8'(INIT_X);
        exp_v = 7'(INIT_Y);
        check_outputs("clear");
        @(negedge clk);
        check("clear_win", 32'(win), 32'd0);
    endtask

    // REACHED while M_STATE=10 must be ignored.
    task automatic pulse_in_win_state();
        m_state = 2'b10;
        reached = 1'b1;
        @(negedge clk);
        reached = 1'b0;
        check_outputs("mwin");
        m_state = 2'b01;
    endtask

    initial begin
        rst     = 1'b1;
        m_state = 2'b01;
        reached = 1'b0;
        exp_score = 0;
        exp_h   = 8'(INIT_X);
        exp_v   = 7'(INIT_Y);
        last_wait = 0;

        // Reset held five cycles, then released on a falling edge.
        repeat (5) @(negedge clk);
        check_outputs("in_reset");
        check("in_reset_win", 32'(win), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_outputs("post_reset");
        check("post_reset_win", 32'(win), 32'd0);

        // First hit sampled on the 2nd edge after release: pairs after edges
        // 2 and 3 are (D2,57) and (A4,2F), both rejected; after edge 4 the
        // pair (48,5F) = (72,95) is accepted, three edges after the hit.
        pulse(1'b0);
        check("first_h", 32'(target_h), 32'd72);
        check("first_v", 32'(target_v), 32'd95);
        check("first_wait", 32'(last_wait), 32'd3);

        // Climb to WIN_SCORE; WIN follows one edge behind the score.
        for (int s = 2; s <= WIN_SCORE; s++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pulse(1'b0);
            check("win_track", 32'(win), (s == WIN_SCORE) ? 32'd1 : 32'd0);
        end

        // Further hit after WIN: no score change, no search, target kept.
        pulse(1'b0);
        check("win_kept", 32'(win), 32'd1);

        clear_game();
        pulse_in_win_state();

        // REACHED held into SEARCH counts once.
        pulse(1'b1);
        check("hold2_score", 32'(score), 32'd1);

        // Reset two cycles into SEARCH, replaying the first-hit timing.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_score = 0;
        exp_h = 8'(INIT_X);
        exp_v = 7'(INIT_Y);
        @(negedge clk);
        reached = 1'b1;
        @(negedge clk);
        reached = 1'b0;
        check("rst_search_enter", 32'(target_valid), 32'd0);
        repeat (2) @(negedge clk);
        check("rst_search_open", 32'(target_valid), 32'd0);
        #1 rst = 1'b1;
        #1;
        check_outputs("async_rst");
        check("async_rst_win", 32'(win), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Random stream of hits, restarting the game whenever it is won.
        for (int k = 0; k < RAND_PULSES; k++) begin
            if (exp_score == WIN_SCORE) begin
                check("rand_win", 32'(win), 32'd1);
                clear_game();
            end
            if ($urandom_range(0, 15) == 0) pulse_in_win_state();
            pulse(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
